// File: rtl/router_fifo.sv
// ---------------------------------------------------------------------------
// router_fifo
// Per-port output buffer of the 1x3 router. Bytes arrive from the
// synchronizer under this port's write enable and are handed to the
// destination client under its read enable. Each entry also keeps the
// header marker (lfd_state), so the read side can follow packet boundaries.
//
// Parameters:
//   DEPTH     - number of entries (power of two, 4..64)
//   WIDTH     - data byte width
//
// Ports:
//   clk       - rising-edge clock
//   rst       - synchronous reset, active-high
//   soft_rst  - synchronous flush (synchronizer timeout), active-high
//   write_enb - store data_in when not full
//   lfd_state - current write is the packet header byte
//   data_in   - byte to store
//   read_enb  - client read request
//   data_out  - registered read data
//   full      - no free entry
//   empty     - no stored entry
//   ovf_err   - sticky overflow/underflow flag (only with ROUTER_FIFO_ERR_EN)
//
// Optional feature macro: ROUTER_FIFO_ERR_EN adds the ovf_err port.
// ---------------------------------------------------------------------------
module router_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             soft_rst,
    input  logic             write_enb,
    input  logic             lfd_state,
    input  logic [WIDTH-1:0] data_in,
    input  logic             read_enb,
    output logic [WIDTH-1:0] data_out,
    output logic             full,
    output logic             empty
`ifdef ROUTER_FIFO_ERR_EN
    ,
    output logic             ovf_err
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = WIDTH - 1;
    localparam logic [AW:0] PTR_ONE = 1;

    // Storage keeps the header marker in the top bit of every entry.
    logic [WIDTH:0]   mem_q [DEPTH];

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    pkt_cnt_q, pkt_cnt_d;
    logic [WIDTH-1:0] data_out_q, data_out_d;

    logic             flush;
    logic             do_write;
    logic             do_read;
    logic [WIDTH:0]   rd_entry;

    // Extra pointer MSB distinguishes full from empty when addresses match.
    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign data_out = data_out_q;

    always_comb begin
        flush    = rst || soft_rst;
        do_write = write_enb && !full && !flush;
        do_read  = read_enb && !empty && !flush;
        rd_entry = mem_q[rd_ptr_q[AW-1:0]];

        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        pkt_cnt_d  = pkt_cnt_q;
        data_out_d = data_out_q;

        if (flush) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            pkt_cnt_d  = '0;
            data_out_d = '0;
        end else begin
            if (do_write) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (do_read) begin
                rd_ptr_d   = rd_ptr_q + PTR_ONE;
                data_out_d = rd_entry[WIDTH-1:0];
                // Header byte carries payload length in its upper bits;
                // the extra one accounts for the trailing parity byte.
                if (rd_entry[WIDTH]) begin
                    pkt_cnt_d = PW'(rd_entry[WIDTH-1:2]) + PW'(1);
                end else if (pkt_cnt_q != '0) begin
                    pkt_cnt_d = pkt_cnt_q - PW'(1);
                end
            end else if (!read_enb && pkt_cnt_q == '0) begin
                // Idle between packets: present a clean zero to the client.
                // A request against an empty FIFO keeps the last byte.
                data_out_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            pkt_cnt_q  <= '0;
            data_out_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            pkt_cnt_q  <= pkt_cnt_d;
            data_out_q <= data_out_d;
        end
    end

    // Memory is not reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (do_write) begin
            mem_q[wr_ptr_q[AW-1:0]] <= {lfd_state, data_in};
        end
    end

`ifdef ROUTER_FIFO_ERR_EN
    logic ovf_err_q, ovf_err_d;

    // Sticky: only the hard reset clears it, the flush leaves it alone.
    always_comb begin
        ovf_err_d = ovf_err_q;
        if (!soft_rst && ((write_enb && full) || (read_enb && empty))) begin
            ovf_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_err_q <= 1'b0;
        end else begin
            ovf_err_q <= ovf_err_d;
        end
    end

    assign ovf_err = ovf_err_q;
`endif

endmodule
